// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD (4 digits) to binary converter, one shift-and-correct step per clock.
// Optional digit validation is enabled by defining BCD_CHECK_EN.
module bcd_to_bin_seq #(
    parameter int unsigned N = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   thousands,
    input  logic [3:0]   hundred,
    input  logic [3:0]   tens,
    input  logic [3:0]   ones,
    output logic [N-1:0] binary,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [15:0]     digits;
    logic [15:0]     bcd;
    logic [15:0]     bcd_shift;
    logic [15:0]     bcd_next;
    logic [N-1:0]    bin;
    logic [N-1:0]    bin_next;
    logic [CW-1:0]   count;
    logic            last_iter;
    logic            digit_bad;

    assign digits    = {thousands, hundred, tens, ones};
    assign last_iter = (count == CW'(N - 1));
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

`ifdef BCD_CHECK_EN
    logic error_q;

    // A nibble exceeds 9 when bit 3 is set together with bit 2 or bit 1.
    assign digit_bad = (thousands[3] & (thousands[2] | thousands[1])) |
                       (hundred[3]   & (hundred[2]   | hundred[1]))   |
                       (tens[3]      & (tens[2]      | tens[1]))      |
                       (ones[3]      & (ones[2]      | ones[1]));
    assign error     = error_q;
`else
    assign digit_bad = 1'b0;
    assign error     = 1'b0;
`endif

    always_comb begin
        bcd_shift = {1'b0, bcd[15:1]};
        bin_next  = {bcd[0], bin[N-1:1]};
        bcd_next  = bcd_shift;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_shift[4*i+3]) begin
                bcd_next[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = digit_bad ? DONE : CONV;
                end
            end
            CONV: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bcd     <= '0;
            bin     <= '0;
            count   <= '0;
            binary  <= '0;
`ifdef BCD_CHECK_EN
            error_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd   <= digits;
                        bin   <= '0;
                        count <= '0;
`ifdef BCD_CHECK_EN
                        if (digit_bad) begin
                            binary  <= '0;
                            error_q <= 1'b1;
                        end
`endif
                    end
                end
                CONV: begin
                    bcd   <= bcd_next;
                    bin   <= bin_next;
                    count <= count + CW'(1);
                    // Result is taken from the final step directly so it is valid in DONE.
                    if (last_iter) begin
                        binary <= bin_next;
`ifdef BCD_CHECK_EN
                        error_q <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (default N=14).
module tb_bcd_to_bin_seq;

    localparam int unsigned N = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   thousands;
    logic [3:0]   hundred;
    logic [3:0]   tens;
    logic [3:0]   ones;
    logic [N-1:0] binary;
    logic         busy;
    logic         done;
    logic         error;

    int compared   = 0;
    int mismatched = 0;

    bcd_to_bin_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .thousands (thousands),
        .hundred   (hundred),
        .tens      (tens),
        .ones      (ones),
        .binary    (binary),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Called at a negedge; drives a start for one posedge, returns one negedge after acceptance.
    task automatic do_start(input logic [3:0] th, input logic [3:0] h,
                            input logic [3:0] t, input logic [3:0] o, input bit hold);
        thousands = th; hundred = h; tens = t; ones = o;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Counts negedges from the current one until done is seen, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < int'(N) + 5) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #2;
        compared++;
        if ({busy, done, error} !== 3'b000 || binary !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: busy=%b done=%b error=%b binary=%0d, required 0 0 0 0",
                     busy, done, error, binary);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero;
        int lat;
        do_start(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        wait_done(lat);
        compared++;
        if (lat !== int'(N)) begin
            mismatched++;
            $display("FAIL zero_latency: got %0d, required %0d", lat, N);
        end
        compared++;
        if (binary !== 14'd0 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_result: binary=%0d error=%b, required 0 0", binary, error);
        end
        @(negedge clk);
    endtask

    task automatic test_1234;
        do_start(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        for (int i = 0; i <= int'(N); i++) begin
            compared++;
            if (busy !== 1'b1) begin
                mismatched++;
                $display("FAIL busy_1234 cycle %0d: got %b, required 1", i, busy);
            end
            compared++;
            if (done !== (i == int'(N))) begin
                mismatched++;
                $display("FAIL done_1234 cycle %0d: got %b, required %b", i, done, i == int'(N));
            end
            if (i < int'(N)) @(negedge clk);
        end
        compared++;
        if (binary !== 14'd1234 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL result_1234: binary=%0d error=%b, required 1234 0", binary, error);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        do_start(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
        wait_done(lat);
        compared++;
        if (binary !== 14'h270F || lat !== int'(N)) begin
            mismatched++;
            $display("FAIL result_9999: binary=%0d lat=%0d, required 9999 %0d", binary, lat, N);
        end
        // start is raised during DONE and held until the following IDLE edge accepts it
        thousands = 4'd0; hundred = 4'd0; tens = 4'd0; ones = 4'd5;
        start = 1'b1;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || binary !== 14'd9999) begin
            mismatched++;
            $display("FAIL b2b_idle: busy=%b binary=%0d, required 0 9999", busy, binary);
        end
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_accept: busy=%b, required 1", busy);
        end
        wait_done(lat);
        compared++;
        if (binary !== 14'd5 || lat !== int'(N)) begin
            mismatched++;
            $display("FAIL result_0005: binary=%0d lat=%0d, required 5 %0d", binary, lat, N);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int lat;
        int pulses;
        do_start(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        @(negedge clk);
        @(negedge clk);
        thousands = 4'd9; hundred = 4'd8; tens = 4'd7; ones = 4'd6;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        compared++;
        if (binary !== 14'd1234 || lat !== int'(N) - 4) begin
            mismatched++;
            $display("FAIL ignore_result: binary=%0d lat=%0d, required 1234 %0d", binary, lat, N - 4);
        end
        pulses = 0;
        for (int i = 0; i < 2 * int'(N) + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        compared++;
        if (pulses !== 0) begin
            mismatched++;
            $display("FAIL ignore_extra_done: got %0d pulses, required 0", pulses);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        int pulses;
        do_start(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        for (int i = 0; i < 5; i++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({busy, done, error} !== 3'b000 || binary !== '0) begin
            mismatched++;
            $display("FAIL abort_outputs: busy=%b done=%b error=%b binary=%0d, required 0 0 0 0",
                     busy, done, error, binary);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 2 * int'(N); i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        compared++;
        if (pulses !== 0) begin
            mismatched++;
            $display("FAIL abort_no_done: got %0d pulses, required 0", pulses);
        end
        do_start(4'd0, 4'd9, 4'd8, 4'd7, 1'b0);
        wait_done(lat);
        compared++;
        if (binary !== 14'd987 || lat !== int'(N)) begin
            mismatched++;
            $display("FAIL after_abort: binary=%0d lat=%0d, required 987 %0d", binary, lat, N);
        end
        @(negedge clk);
    endtask

    task automatic test_invalid_digit;
        int lat;
        do_start(4'd0, 4'hA, 4'd0, 4'd0, 1'b0);
        wait_done(lat);
`ifdef BCD_CHECK_EN
        compared++;
        if (lat !== 0 || error !== 1'b1 || binary !== '0) begin
            mismatched++;
            $display("FAIL invalid_checked: lat=%0d error=%b binary=%0d, required 0 1 0",
                     lat, error, binary);
        end
`else
        compared++;
        if (lat !== int'(N) || error !== 1'b0) begin
            mismatched++;
            $display("FAIL invalid_unchecked: lat=%0d error=%b, required %0d 0", lat, error, N);
        end
`endif
        @(negedge clk);
        do_start(4'd4, 4'd0, 4'd0, 4'd2, 1'b0);
        wait_done(lat);
        compared++;
        if (binary !== 14'd4002 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL after_invalid: binary=%0d error=%b, required 4002 0", binary, error);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        thousands = 4'd0; hundred = 4'd0; tens = 4'd0; ones = 4'd0;
        test_reset;
        test_zero;
        test_1234;
        test_back_to_back;
        test_ignore_start;
        test_reset_abort;
        test_invalid_digit;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
